// File: rtl/cmsdk_ahb_region_decoder.sv
// cmsdk_ahb_region_decoder: AHB-Lite base/mask region decoder with boot remap,
// registered data-phase response mux, two-cycle ERROR default slave and first-error capture.
module cmsdk_ahb_region_decoder #(
  parameter int NUM_REGIONS = 8,
  parameter logic [32*NUM_REGIONS-1:0] REGION_BASE = {8{32'h0}},
  parameter logic [32*NUM_REGIONS-1:0] REGION_MASK = {8{32'hFFFF_0000}},
  parameter int BOOT_REGION = 0,
  parameter int REMAP_EN = 0
) (
  input  logic                     hclk,
  input  logic                     hreset,
  input  logic [31:0]              haddr,
  input  logic [1:0]               htrans,
  input  logic                     hready,
  input  logic                     remap_ctrl,
  output logic [NUM_REGIONS-1:0]   hsel,
  input  logic [NUM_REGIONS-1:0]   hreadyout_s,
  input  logic [NUM_REGIONS-1:0]   hresp_s,
  input  logic [32*NUM_REGIONS-1:0] hrdata_s,
  output logic                     hreadyout,
  output logic                     hresp,
  output logic [31:0]              hrdata,
  output logic                     err_valid,
  output logic [31:0]              err_addr,
  input  logic                     err_clr
);
  typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;
  state_t state_q, state_d;
  logic [NUM_REGIONS-1:0] hit, dsel_q, dsel_d;
  logic remap, start_err, cap;
  logic err_valid_q, err_valid_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic mux_rdy, mux_resp;
  logic [31:0] mux_data;
  logic unused_htrans;
  assign unused_htrans = htrans[0];
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_REGIONS; i++)
      hit[i] = (haddr & REGION_MASK[32*i +: 32]) == (REGION_BASE[32*i +: 32] & REGION_MASK[32*i +: 32]);
  end
  // hit & -hit isolates the lowest-index hit, keeping hsel one-hot on overlap
  assign remap = (REMAP_EN != 0) && remap_ctrl && (haddr[31:16] == 16'h0000);
  assign hsel = remap ? NUM_REGIONS'(1) << BOOT_REGION : hit & (~hit + NUM_REGIONS'(1));
  assign start_err = hready && !(|hsel) && htrans[1];
  assign cap = start_err && (state_q != ERR1) && !err_valid_q;
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= IDLE;
      dsel_q <= '0;
      err_valid_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      dsel_q <= dsel_d;
      err_valid_q <= err_valid_d;
      err_addr_q <= err_addr_d;
    end
  end
  always_comb begin
    state_d = state_q == ERR1 ? ERR2 : start_err ? ERR1 : IDLE;
    dsel_d = hready ? hsel : dsel_q;
    err_valid_d = cap | (err_valid_q & ~err_clr);
    err_addr_d = cap ? haddr : err_clr ? 32'h0 : err_addr_q;
  end
  // an all-zero dsel is the NONE select, answered by the default slave
  always_comb begin
    mux_rdy = 1'b1;
    mux_resp = 1'b0;
    mux_data = '0;
    for (int i = 0; i < NUM_REGIONS; i++)
      if (dsel_q[i]) begin
        mux_rdy = hreadyout_s[i];
        mux_resp = hresp_s[i];
        mux_data = hrdata_s[32*i +: 32];
      end
    hreadyout = |dsel_q ? mux_rdy : state_q != ERR1;
    hresp = |dsel_q ? mux_resp : state_q != IDLE;
    hrdata = mux_data;
  end
  assign err_valid = err_valid_q;
  assign err_addr = err_addr_q;
endmodule
